// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball ball motion logic.
package pinball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOST = 2'd2
  } ball_state_e;

  // Position and speed are signed 32-bit fixed point with 6 fractional bits.
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FRAC_BITS              = 6;

  // Last visible pixel column / row of the 640x480 screen.
  localparam int SCREEN_MAX_X = 639;
  localparam int SCREEN_MAX_Y = 479;

  // Horizontal speed given on launch: one pixel per frame.
  localparam int LAUNCH_X_SPEED = FIXED_POINT_MULTIPLIER;

  // Fixed point to whole pixels (floor, sign preserved).
  function automatic logic signed [31:0] to_pixels(input logic signed [31:0] fp);
    return fp >>> FRAC_BITS;
  endfunction

endpackage

// File: rtl/ball_move_ctrl_if.sv
// Frame-rate control inputs and ball position/status outputs of the ball mover.
interface ball_move_ctrl_if;
  logic               startOfFrame;
  logic               launch;
  logic               flipperHit;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               ballLost;
  logic               running;

  modport slave (
    input  startOfFrame, launch, flipperHit,
    output topLeftX, topLeftY, ballLost, running
  );

  modport master (
    output startOfFrame, launch, flipperHit,
    input  topLeftX, topLeftY, ballLost, running
  );
endinterface

// File: rtl/ball_move_ctrl_speed_limiter.sv
// Symmetric saturation of a signed speed to [-MAX_SPEED, +MAX_SPEED].
module speed_limiter #(
  parameter int MAX_SPEED = 512
) (
  input  logic signed [31:0] speed_i,
  output logic signed [31:0] speed_o
);

  localparam logic signed [31:0] POS_LIMIT = 32'(MAX_SPEED);
  localparam logic signed [31:0] NEG_LIMIT = -32'(MAX_SPEED);

  // Clamp to whichever bound is exceeded, pass through otherwise.
  always_comb begin
    speed_o = speed_i;
    if (speed_i > POS_LIMIT) begin
      speed_o = POS_LIMIT;
    end else if (speed_i < NEG_LIMIT) begin
      speed_o = NEG_LIMIT;
    end
  end

endmodule

// File: rtl/ball_move_ctrl.sv
// Ball motion controller: park, launch, gravity flight with wall/flipper bounces, lost timeout.
module ball_move_ctrl
  import pinball_pkg::*;
#(
  parameter int INITIAL_X       = 300,
  parameter int INITIAL_Y       = 400,
  parameter int LAUNCH_Y_SPEED  = -256,
  parameter int GRAVITY         = 4,
  parameter int MAX_Y_SPEED     = 512,
  parameter int LOST_FRAMES     = 60,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32
) (
  input logic             clk,
  input logic             resetN,
  ball_move_ctrl_if.slave bus
);

  localparam logic signed [31:0] INIT_X_FP = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] INIT_Y_FP = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
  localparam logic [31:0]        LOST_LOAD = 32'(LOST_FRAMES - 1);

  ball_state_e        state_q, state_d;
  logic               running_q, lost_q;
  logic signed [31:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] xs_q, xs_d, ys_q, ys_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               pend_q, pend_d;

  logic signed [31:0] x_px, y_px;
  logic signed [31:0] base_xs, base_ys;
  logic signed [31:0] xs_bnc, ys_bnc;
  logic signed [31:0] ys_grav, ys_lim;
  logic               hit_now;

  assign x_px    = to_pixels(x_q);
  assign y_px    = to_pixels(y_q);
  // A hit arriving on the frame pulse itself still counts for this frame.
  assign hit_now = pend_q | bus.flipperHit;

  // When leaving IDLE the launch speeds go through the same update path as a running frame.
  assign base_xs = (state_q == ST_IDLE) ? 32'(LAUNCH_X_SPEED) : xs_q;
  assign base_ys = (state_q == ST_IDLE) ? 32'(LAUNCH_Y_SPEED) : ys_q;

  // Reflections judged on the pre-move position; X and Y are independent so a corner flips both.
  always_comb begin
    xs_bnc = base_xs;
    ys_bnc = base_ys;
    if (((x_px <= 0) && (base_xs < 0)) ||
        ((x_px + OBJECT_WIDTH_X >= SCREEN_MAX_X) && (base_xs > 0))) begin
      xs_bnc = -base_xs;
    end
    if ((hit_now && (base_ys > 0)) || ((y_px <= 0) && (base_ys < 0))) begin
      ys_bnc = -base_ys;
    end
  end

  assign ys_grav = ys_bnc + 32'(GRAVITY);

  speed_limiter #(
    .MAX_SPEED (MAX_Y_SPEED)
  ) u_speed_limiter (
    .speed_i (ys_grav),
    .speed_o (ys_lim)
  );

  // Next state and next datapath values; nothing moves except on the frame pulse.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | bus.flipperHit;
    if (bus.startOfFrame) begin
      pend_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          x_d  = INIT_X_FP;
          y_d  = INIT_Y_FP;
          xs_d = '0;
          ys_d = '0;
          if (bus.launch) begin
            state_d = ST_RUN;
            xs_d    = xs_bnc;
            ys_d    = ys_lim;
            x_d     = x_q + xs_bnc;
            y_d     = y_q + ys_lim;
          end
        end
        ST_RUN: begin
          if (y_px >= SCREEN_MAX_Y) begin
            state_d = ST_LOST;
            xs_d    = '0;
            ys_d    = '0;
            cnt_d   = LOST_LOAD;
          end else begin
            xs_d = xs_bnc;
            ys_d = ys_lim;
            x_d  = x_q + xs_bnc;
            y_d  = y_q + ys_lim;
          end
        end
        ST_LOST: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            x_d     = INIT_X_FP;
            y_d     = INIT_Y_FP;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with status flags decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      lost_q    <= (state_d == ST_LOST);
    end
  end

  // Position, speed, lost-frame counter and pending flipper hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q    <= INIT_X_FP;
      y_q    <= INIT_Y_FP;
      xs_q   <= '0;
      ys_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xs_q   <= xs_d;
      ys_q   <= ys_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign bus.topLeftX = x_px[10:0];
  assign bus.topLeftY = y_px[10:0];
  assign bus.running  = running_q;
  assign bus.ballLost = lost_q;

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Randomised scoreboard bench for ball_move_ctrl against a frame-level reference model.
module tb_ball_move_ctrl;

  localparam int INIT_X    = 300;
  localparam int INIT_Y    = 400;
  localparam int LAUNCH_VY = -256;
  localparam int GRAV      = 4;
  localparam int MAX_VY    = 512;
  localparam int LOST_N    = 60;
  localparam int OBJ_W     = 32;
  localparam int OBJ_H     = 32;
  localparam int N_FRAMES  = 4000;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOST = 2;

  typedef struct {
    int x;
    int y;
    int run;
    int lost;
    int frame;
  } exp_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  ball_move_ctrl_if bus ();

  ball_move_ctrl #(
    .INITIAL_X       (INIT_X),
    .INITIAL_Y       (INIT_Y),
    .LAUNCH_Y_SPEED  (LAUNCH_VY),
    .GRAVITY         (GRAV),
    .MAX_Y_SPEED     (MAX_VY),
    .LOST_FRAMES     (LOST_N),
    .OBJECT_WIDTH_X  (OBJ_W),
    .OBJECT_HEIGHT_Y (OBJ_H)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model: ball in pixels*64, mode, frames left in LOST, latched hit.
  longint mx, my, mvx, mvy;
  int     mode;
  int     lost_left;
  bit     pend;
  int     frame_no   = 0;
  int     keep_alive = 0;
  logic   sof_edge   = 1'b0;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic check_all(input string nm, input exp_t e);
    cmp({nm, "_x"}, int'(bus.topLeftX), e.x);
    cmp({nm, "_y"}, int'(bus.topLeftY), e.y);
    cmp({nm, "_running"}, int'(bus.running), e.run);
    cmp({nm, "_ballLost"}, int'(bus.ballLost), e.lost);
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic signed [10:0] tx, ty;
    tx = 11'(mx >>> 6);
    ty = 11'(my >>> 6);
    e.x = int'(tx);
    e.y = int'(ty);
    e.run = (mode == M_RUN) ? 1 : 0;
    e.lost = (mode == M_LOST) ? 1 : 0;
    e.frame = frame_no;
    return e;
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    mx = longint'(INIT_X) * 64;
    my = longint'(INIT_Y) * 64;
    mvx = 0;
    mvy = 0;
    lost_left = 0;
    pend = 1'b0;
  endtask

  // One frame of flight from the given pre-move pixel position.
  task automatic move_ball(input bit hit, input longint px, input longint py);
    if ((px <= 0 && mvx < 0) || (px + OBJ_W >= 639 && mvx > 0)) mvx = -mvx;
    if ((hit && mvy > 0) || (py <= 0 && mvy < 0)) mvy = -mvy;
    mvy = mvy + GRAV;
    if (mvy > MAX_VY) mvy = MAX_VY;
    if (mvy < -MAX_VY) mvy = -MAX_VY;
    mx = mx + mvx;
    my = my + mvy;
  endtask

  task automatic model_frame(input bit la, input bit hit_now);
    bit hit;
    longint px, py;
    hit = pend | hit_now;
    pend = 1'b0;
    px = mx >>> 6;
    py = my >>> 6;
    if (mode == M_IDLE) begin
      if (la) begin
        mode = M_RUN;
        mvx = 64;
        mvy = LAUNCH_VY;
        move_ball(hit, px, py);
      end
    end else if (mode == M_RUN) begin
      if (py >= 479) begin
        mode = M_LOST;
        mvx = 0;
        mvy = 0;
        lost_left = LOST_N;
      end else begin
        move_ball(hit, px, py);
      end
    end else begin
      lost_left--;
      if (lost_left == 0) begin
        mode = M_IDLE;
        mx = longint'(INIT_X) * 64;
        my = longint'(INIT_Y) * 64;
      end
    end
  endtask

  // Optional gap cycles (with an optional mid-frame hit), then one frame pulse.
  task automatic do_frame(input bit la, input bit hit_mid, input bit hit_sof, input int gap);
    exp_t e;
    bus.launch = la;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.flipperHit = hit_mid && (i == 0);
      if (hit_mid && (i == 0)) pend = 1'b1;
    end
    @(negedge clk);
    bus.flipperHit   = hit_sof;
    bus.startOfFrame = 1'b1;
    frame_no++;
    model_frame(la, hit_sof);
    e = predict();
    exp_q.push_back(e);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.flipperHit   = 1'b0;
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1 model_reset();
    keep_alive = 0;
    check_all("async_reset", predict());
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: after every frame pulse edge, pop the expected outcome and compare.
  always @(posedge clk) sof_edge <= bus.startOfFrame;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sof_edge) begin
      if (exp_q.size() == 0) begin
        cmp("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        $display("frame %0d x=%0d y=%0d running=%0b ballLost=%0b",
                 e.frame, bus.topLeftX, bus.topLeftY, bus.running, bus.ballLost);
        check_all($sformatf("frame%0d", e.frame), e);
      end
    end
  end

  initial begin : stimulus
    bit la, hit, at_sof, hit_mid, hit_sof;
    int gap;
    bus.startOfFrame = 1'b0;
    bus.launch       = 1'b0;
    bus.flipperHit   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", predict());
    cmp("reset_x_const", int'(bus.topLeftX), INIT_X);
    cmp("reset_y_const", int'(bus.topLeftY), INIT_Y);
    resetN = 1'b1;

    // Launch held without any frame pulse must not move the ball.
    bus.launch = 1'b1;
    repeat (6) @(negedge clk);
    check_all("launch_no_frame", predict());

    // First launch frame: one pixel right, (-256+4)>>6 = -4 pixels up.
    keep_alive = 400;
    do_frame(1'b1, 1'b0, 1'b0, 1);
    cmp("launch_x_const", int'(bus.topLeftX), 301);
    cmp("launch_y_const", int'(bus.topLeftY), 396);
    cmp("launch_running", int'(bus.running), 1);
    bus.launch = 1'b0;

    for (int f = 0; f < N_FRAMES; f++) begin
      la = ($urandom_range(0, 2) == 0);
      if (mode == M_IDLE && la) keep_alive = $urandom_range(30, 800);
      if (keep_alive > 0 && (my >>> 6) > 380) hit = ($urandom_range(0, 1) == 1);
      else hit = ($urandom_range(0, 29) == 0);
      if (keep_alive > 0) keep_alive--;
      at_sof  = ($urandom_range(0, 1) == 1);
      gap     = $urandom_range(0, 3);
      hit_mid = hit && !at_sof && (gap > 0);
      hit_sof = hit && (at_sof || gap == 0);
      do_frame(la, hit_mid, hit_sof, gap);
      if ($urandom_range(0, 499) == 0) async_reset_mid();
    end

    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_move_ctrl.md
BALL_MOVE_CTRL -- requirements
Module: ball_move_ctrl

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- INITIAL_X, 300, parked top-left X in pixels
- INITIAL_Y, 400, parked top-left Y in pixels
- LAUNCH_Y_SPEED, -256, Y speed loaded on launch (fixed-point units per frame)
- GRAVITY, 4, added to Y speed each running frame
- MAX_Y_SPEED, 512, Y speed saturation magnitude
- LOST_FRAMES, 60, frames spent in LOST before re-park
- OBJECT_WIDTH_X, 32, ball width in pixels
- OBJECT_HEIGHT_Y, 32, ball height in pixels
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock
- resetN, in, 1, asynchronous active-low reset
- startOfFrame, in, 1, one-cycle pulse per VGA frame
- launch, in, 1, level; starts the ball from IDLE
- flipperHit, in, 1, pulse when ball and flipper drawing requests overlap
- topLeftX, out, signed 11, ball position fed to the square object
- topLeftY, out, signed 11, ball position fed to the square object
- ballLost, out, 1, high while in LOST
- running, out, 1, high while in RUN

Function
REQ-003 Position and speed SHALL be held internally as signed 32-bit fixed point with 6 fractional bits (FIXED_POINT_MULTIPLIER = 64); outputs SHALL be the internal value arithmetic-shifted right by 6 and truncated to 11 bits.
REQ-004 The FSM SHALL have states IDLE, RUN, LOST; all state changes and position/speed updates SHALL occur only in the cycle where startOfFrame = 1.
REQ-005 In IDLE, position SHALL equal (INITIAL_X, INITIAL_Y) and both speeds SHALL be 0; if launch = 1 at startOfFrame the state SHALL go to RUN with Yspeed = LAUNCH_Y_SPEED and Xspeed = 64.
REQ-006 In RUN, at each startOfFrame: Yspeed += GRAVITY, saturated to [-MAX_Y_SPEED, +MAX_Y_SPEED]; then X += Xspeed and Y += Yspeed (using the speeds after the update).
REQ-007 flipperHit SHALL be latched into a pending flag at any cycle. At the next startOfFrame, if the flag is set and Yspeed > 0, Yspeed SHALL be negated before the gravity add. The flag SHALL clear on every startOfFrame.
REQ-008 Wall bounces SHALL be evaluated at startOfFrame on the pre-move position, in pixels:
- X <= 0 with Xspeed < 0: negate Xspeed
- X + OBJECT_WIDTH_X >= 639 with Xspeed > 0: negate Xspeed
- Y <= 0 with Yspeed < 0: negate Yspeed
REQ-009 If the pre-move Y >= 479 in RUN, the state SHALL go to LOST, speeds SHALL be zeroed, position SHALL freeze, and a frame counter SHALL load LOST_FRAMES-1.
REQ-010 In LOST, the counter SHALL decrement on each startOfFrame. When the counter is 0 at startOfFrame, the state SHALL go to IDLE and position SHALL be reloaded.
REQ-011 launch SHALL be ignored outside IDLE. A flipperHit arriving in the same cycle as startOfFrame SHALL apply at that frame boundary.
REQ-012 Simultaneous bounce conditions (corner) SHALL negate both affected speeds in the same frame.
REQ-013 Outputs running and ballLost SHALL be registered decodes of the state, with the same cycle alignment as the state.

Reset
REQ-014 On resetN = 0, asynchronously:
- state = IDLE
- position = (INITIAL_X, INITIAL_Y) in fixed point
- speeds = 0, counter = 0, pending flag = 0
- ballLost = 0, running = 0
Reset asserted mid-RUN SHALL discard motion. The first startOfFrame after release SHALL be evaluated normally.

Structure
REQ-015 The state enum, FIXED_POINT_MULTIPLIER, and screen bounds 639/479 SHALL live in a shared package (pinball_pkg).
REQ-016 Speed saturation SHALL be a small sub-module, speed_limiter; everything else SHALL be a single FSM plus a datapath always_ff.

Verification
REQ-017 Reset, then launch = 1 with one startOfFrame -> running = 1, topLeftY = 400 + ((-256 + 4) >> 6) = 396, topLeftX = 301.
REQ-018 RUN with Yspeed = +128 and flipperHit pulsed mid-frame -> next frame Yspeed = -124, Y decreases by 2 pixels.
REQ-019 Ball at X = 607 (607 + 32 >= 639) with Xspeed = +64 -> Xspeed becomes -64 and X = 606 after the frame.
REQ-020 Ball reaches Y >= 479 -> ballLost = 1 for exactly 60 frames, then IDLE with position (300, 400).
REQ-021 Hold launch without frames -> no movement. Assert resetN low mid-RUN -> outputs return to (300, 400) immediately, asynchronously.
REQ-022 Free fall from Yspeed = 500 with GRAVITY = 4 -> Yspeed clamps at 512 and never exceeds it.
